aes_core: RTL and testbench

- Iterative AES-128 block cipher engine (FIPS-197), one round per clock; encrypts or decrypts one 128-bit block per transaction, selected per block by `enc`.
- Key is loaded by a `key_ld_p` pulse and expanded on the fly.
- Sits between a valid/ready block source and a valid/ready sink.
- The sink applies arbitrary backpressure on `dout_rdy`.

---
 rtl/aes_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_aes_core.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core.sv
// Iterative AES-128 engine, one round per clock, encrypt or decrypt per block.
// The key is expanded once after key_ld_p to capture rk10. During a block the
// round keys are regenerated on the fly: forward from rk0 when encrypting,
// backward from rk10 when decrypting.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   key_ld_p, key     key-load strobe and 128-bit key ([127:120] = byte 0)
//   enc               1 = encrypt, 0 = decrypt; captured with the input block
//   din_vld, din_rdy  input block handshake; din is the 128-bit block
//   dout_vld, dout_rdy result handshake; dout is held stable while waiting
module aes_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_ld_p,
  input  logic [127:0] key,
  input  logic         enc,
  input  logic         din_vld,
  input  logic [127:0] din,
  output logic         din_rdy,
  output logic         dout_vld,
  output logic [127:0] dout,
  input  logic         dout_rdy
);

  typedef enum logic [2:0] {StIdle, StKexp, StReady, StRun, StDone} state_e;

  // ---------------- GF(2^8) and S-box helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);  // exponent 2^(i+2)-1
    return gmul(r, r);
  endfunction

  // One shared inverter serves both directions; only the affine step differs.
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [7:0] t;
    logic [7:0] g;
    t = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
    g = ginv(t);
    if (inv) return g;
    return g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8], inv);
    return o;
  endfunction

  // Byte index = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    if (!inv) begin
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- registers ----------------
  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] wkey_q, wkey_d;
  logic [127:0] rk0_q, rk0_d;
  logic [127:0] rk10_q, rk10_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         enc_q, enc_d;

  // ---------------- key schedule step ----------------
  logic         dec_key;
  logic [3:0]   ridx;
  logic [31:0]  w0, w1, w2, w3, gin, gw;
  logic [127:0] nkey;

  always_comb begin
    dec_key = (fsm_q == StRun) && !enc_q;
    // Decrypt round r needs rk(10-r), undoing the step that used Rcon[11-r].
    ridx = dec_key ? (4'd11 - rnd_q) : rnd_q;
    {w0, w1, w2, w3} = wkey_q;
    // Backward, the previous word 3 is w3 ^ w2 and feeds the same g() path.
    gin = dec_key ? (w3 ^ w2) : w3;
    gw  = {sbox(gin[23:16], 1'b0), sbox(gin[15:8], 1'b0),
           sbox(gin[7:0], 1'b0), sbox(gin[31:24], 1'b0)} ^ {rcon(ridx), 24'h0};
    if (dec_key) begin
      nkey = {w0 ^ gw, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end else begin
      nkey[127:96] = w0 ^ gw;
      nkey[95:64]  = w1 ^ nkey[127:96];
      nkey[63:32]  = w2 ^ nkey[95:64];
      nkey[31:0]   = w3 ^ nkey[63:32];
    end
  end

  // ---------------- round datapath ----------------
  // Sub and shift are byte-wise and commute, so decrypt reuses the enc order.
  logic         last;
  logic [127:0] sr_out, ark, mixed, round_out;

  always_comb begin
    last      = (rnd_q == 4'd10);
    sr_out    = shift_rows(sub_bytes(st_q, ~enc_q), ~enc_q);
    ark       = sr_out ^ nkey;
    mixed     = mix_columns(enc_q ? sr_out : ark, ~enc_q);
    if (enc_q) round_out = (last ? sr_out : mixed) ^ nkey;
    else       round_out = last ? ark : mixed;
  end

  // ---------------- control ----------------
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    wkey_d = wkey_q;
    rk0_d  = rk0_q;
    rk10_d = rk10_q;
    rnd_d  = rnd_q;
    enc_d  = enc_q;
    unique case (fsm_q)
      StIdle: begin
        if (key_ld_p) begin
          rk0_d  = key;
          wkey_d = key;
          rnd_d  = 4'd1;
          fsm_d  = StKexp;
        end
      end
      StKexp: begin
        wkey_d = nkey;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          rk10_d = nkey;
          fsm_d  = StReady;
        end
      end
      StReady: begin
        if (key_ld_p) begin
          rk0_d  = key;
          wkey_d = key;
          rnd_d  = 4'd1;
          fsm_d  = StKexp;
        end else if (din_vld) begin
          enc_d  = enc;
          st_d   = din ^ (enc ? rk0_q : rk10_q);
          wkey_d = enc ? rk0_q : rk10_q;
          rnd_d  = 4'd1;
          fsm_d  = StRun;
        end
      end
      StRun: begin
        st_d   = round_out;
        wkey_d = nkey;
        rnd_d  = rnd_q + 4'd1;
        if (last) fsm_d = StDone;
      end
      StDone: begin
        if (dout_rdy) fsm_d = StReady;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= StIdle;
      st_q   <= '0;
      wkey_q <= '0;
      rk0_q  <= '0;
      rk10_q <= '0;
      rnd_q  <= '0;
      enc_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      wkey_q <= wkey_d;
      rk0_q  <= rk0_d;
      rk10_q <= rk10_d;
      rnd_q  <= rnd_d;
      enc_q  <= enc_d;
    end
  end

  assign din_rdy  = (fsm_q == StReady) && !key_ld_p;
  assign dout_vld = (fsm_q == StDone);
  assign dout     = st_q;

endmodule

// File: tb/tb_aes_core.sv
module tb_aes_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_ld_p = 1'b0;
  logic [127:0] key = '0;
  logic         enc = 1'b0;
  logic         din_vld = 1'b0;
  logic [127:0] din = '0;
  logic         din_rdy;
  logic         dout_vld;
  logic [127:0] dout;
  logic         dout_rdy = 1'b1;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_ld_p (key_ld_p),
    .key      (key),
    .enc      (enc),
    .din_vld  (din_vld),
    .din      (din),
    .din_rdy  (din_rdy),
    .dout_vld (dout_vld),
    .dout     (dout),
    .dout_rdy (dout_rdy)
  );

  // ---------------- reference model ----------------
  logic [7:0]  sb[256];
  logic [7:0]  isb[256];
  logic [31:0] ew[44];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] r;
    logic [7:0] p;
    r = '0;
    p = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Walk p through powers of 3 while q tracks its inverse, then apply affine.
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  task automatic model(input logic [127:0] k, input logic e, input logic [127:0] d,
                       output logic [127:0] r);
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tw;
    for (int i = 0; i < 4; i++) ew[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = ew[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      ew[i] = ew[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
    if (e) begin
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ew[i/4][31-8*(i%4) -: 8];
      for (int rn = 1; rn <= 10; rn++) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
        s = t;
        if (rn < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = mulc(a0, 4'd2) ^ mulc(a1, 4'd3) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ mulc(a1, 4'd2) ^ mulc(a2, 4'd3) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ mulc(a2, 4'd2) ^ mulc(a3, 4'd3);
            s[4*c+3] = mulc(a0, 4'd3) ^ a1 ^ a2 ^ mulc(a3, 4'd2);
          end
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ ew[4*rn+i/4][31-8*(i%4) -: 8];
      end
    end else begin
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ew[40+i/4][31-8*(i%4) -: 8];
      for (int rn = 9; rn >= 0; rn--) begin
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+4-rw)%4)];
        s = t;
        for (int i = 0; i < 16; i++) s[i] = isb[s[i]];
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ ew[4*rn+i/4][31-8*(i%4) -: 8];
        if (rn > 0) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = mulc(a0, 4'd14) ^ mulc(a1, 4'd11) ^ mulc(a2, 4'd13) ^ mulc(a3, 4'd9);
            s[4*c+1] = mulc(a0, 4'd9) ^ mulc(a1, 4'd14) ^ mulc(a2, 4'd11) ^ mulc(a3, 4'd13);
            s[4*c+2] = mulc(a0, 4'd13) ^ mulc(a1, 4'd9) ^ mulc(a2, 4'd14) ^ mulc(a3, 4'd11);
            s[4*c+3] = mulc(a0, 4'd11) ^ mulc(a1, 4'd13) ^ mulc(a2, 4'd9) ^ mulc(a3, 4'd14);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
  endtask

  // ---------------- drivers (inputs change on the falling edge) ----------------
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key      = k;
    key_ld_p = 1'b1;
    @(negedge clk);
    key_ld_p = 1'b0;
    key      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(input logic e, input logic [127:0] d);
    enc     = e;
    din     = d;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    din     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (din_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (dout_vld !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n   = 1'b0;
    din_vld = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (din_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_din_rdy: got %b expected 0", din_rdy);
    end
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++; $display("FAIL reset_dout_vld: got %b expected 0", dout_vld);
    end
    checks++;
    if (dout !== 128'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected 0", dout);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (din_rdy !== 1'b0 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept: din_rdy=%b dout_vld=%b expected 0/0", din_rdy, dout_vld);
    end
    din_vld = 1'b0;
  endtask

  task automatic test_encrypt_fips;
    int n;
    load_key(K1);
    wait_rdy(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL kexp_latency: got %0d expected 10", n);
    end
    checks++;
    if (dut.rk10_q !== RK10) begin
      errors++; $display("FAIL rk10: got %h expected %h", dut.rk10_q, RK10);
    end
    send(1'b1, PT1);
    wait_vld(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL enc_latency: got %0d expected 10", n);
    end
    checks++;
    if (dout !== CT1) begin
      errors++; $display("FAIL enc_fips: got %h expected %h", dout, CT1);
    end
    @(negedge clk);
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++; $display("FAIL rdy_after_done: got %b expected 1", din_rdy);
    end
  endtask

  task automatic test_decrypt_fips;
    int n;
    load_key(K2);
    wait_rdy(n);
    send(1'b0, CT2);
    wait_vld(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL dec_latency: got %0d expected 10", n);
    end
    checks++;
    if (dout !== PT2) begin
      errors++; $display("FAIL dec_fips: got %h expected %h", dout, PT2);
    end
    @(negedge clk);
  endtask

  task automatic test_roundtrip;
    int n;
    logic [127:0] c, exp_c;
    load_key(K1);
    wait_rdy(n);
    send(1'b1, PT2);
    wait_vld(n);
    c = dout;
    model(K1, 1'b1, PT2, exp_c);
    checks++;
    if (c !== exp_c) begin
      errors++; $display("FAIL rt_enc: got %h expected %h", c, exp_c);
    end
    @(negedge clk);
    wait_rdy(n);
    send(1'b0, c);
    wait_vld(n);
    checks++;
    if (dout !== PT2) begin
      errors++; $display("FAIL rt_dec: got %h expected %h", dout, PT2);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n;
    dout_rdy = 1'b0;
    wait_rdy(n);
    send(1'b1, PT1);
    wait_vld(n);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== CT1 || din_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: vld=%b rdy=%b dout=%h expected 1/0/%h",
                 i, dout_vld, din_rdy, dout, CT1);
      end
      @(negedge clk);
    end
    dout_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: din_rdy=%b dout_vld=%b expected 1/0", din_rdy, dout_vld);
    end
  endtask

  task automatic test_priority;
    int n;
    wait_rdy(n);
    key      = K2;
    key_ld_p = 1'b1;
    enc      = 1'b1;
    din      = PT1;
    din_vld  = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b0) begin
      errors++; $display("FAIL prio_din_rdy: got %b expected 0", din_rdy);
    end
    @(negedge clk);
    key_ld_p = 1'b0;
    din_vld  = 1'b0;
    wait_rdy(n);
    checks++;
    if (n != 10 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL prio_kexp: latency %0d vld=%b expected 10/0", n, dout_vld);
    end
    // Key strobe while a block is running must be ignored.
    send(1'b1, PT2);
    repeat (3) @(negedge clk);
    key      = K1;
    key_ld_p = 1'b1;
    @(negedge clk);
    key_ld_p = 1'b0;
    wait_vld(n);
    checks++;
    if (dout !== CT2) begin
      errors++; $display("FAIL run_keyld_ignored: got %h expected %h", dout, CT2);
    end
    @(negedge clk);
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++; $display("FAIL run_keyld_no_kexp: din_rdy=%b expected 1", din_rdy);
    end
    send(1'b0, CT2);
    wait_vld(n);
    checks++;
    if (dout !== PT2) begin
      errors++; $display("FAIL keep_rk10: got %h expected %h", dout, PT2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int n;
    wait_rdy(n);
    send(1'b1, PT2);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b0 || din_rdy !== 1'b0 || dout !== 128'h0) begin
      errors++;
      $display("FAIL midrun_reset: vld=%b rdy=%b dout=%h expected 0/0/0",
               dout_vld, din_rdy, dout);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    din_vld = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (din_rdy !== 1'b0 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_needs_key: rdy=%b vld=%b expected 0/0", din_rdy, dout_vld);
    end
    din_vld = 1'b0;
    load_key(K2);
    wait_rdy(n);
    send(1'b1, PT2);
    wait_vld(n);
    checks++;
    if (dout !== CT2) begin
      errors++; $display("FAIL post_reset_enc: got %h expected %h", dout, CT2);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int n;
    logic [127:0] k, d, exp_r;
    logic e;
    for (int v = 0; v < 1000; v++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      model(k, e, d, exp_r);
      load_key(k);
      wait_rdy(n);
      if (n >= 40) begin
        checks++; errors++;
        $display("FAIL rand_rdy_timeout vec %0d: waited %0d cycles", v, n);
        break;
      end
      send(e, d);
      wait_vld(n);
      checks++;
      if (n >= 40 || dout !== exp_r) begin
        errors++;
        $display("FAIL rand vec %0d enc=%b: got %h expected %h (wait %0d)",
                 v, e, dout, exp_r, n);
      end
      @(negedge clk);
      if (errors > 20) break;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_encrypt_fips();
    test_decrypt_fips();
    test_roundtrip();
    test_backpressure();
    test_priority();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
